// File: rtl/i2s_audio_transmitter.sv
// I2S master transmitter.
// Holds one PCM word per channel, generates bclk/ws from sys_clk, and shifts
// each word out MSB-first on sd. Everything runs in the sys_clk domain; the
// serial clock is a registered divided output, never used as a clock here.
module i2s_audio_transmitter #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int CLK_DIV      = 2
) (
  input  logic                    sys_clk,
  input  logic                    sys_rst,
  input  logic                    tx_en,
  input  logic [SAMPLE_WIDTH-1:0] sample_in,
  input  logic                    sample_valid,
  input  logic                    channel_id,
  output logic                    sample_ready,
  output logic                    i2s_bclk,
  output logic                    i2s_ws,
  output logic                    i2s_sd,
  output logic                    underrun,
  output logic                    busy
);

  localparam int FRAME_BITS = 2 * SAMPLE_WIDTH;
  localparam int POS_W      = $clog2(FRAME_BITS);
  localparam int DIV_W      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  // Bit position of the last bit of a frame, the first bit of the right slot,
  // and the position at which ws goes high (one bit ahead of the right word).
  localparam logic [POS_W-1:0] POS_LAST    = POS_W'(FRAME_BITS - 1);
  localparam logic [POS_W-1:0] POS_HALF    = POS_W'(SAMPLE_WIDTH);
  localparam logic [POS_W-1:0] POS_WS_RISE = POS_W'(SAMPLE_WIDTH - 1);
  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(CLK_DIV - 1);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_TX   = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [DIV_W-1:0]        div_q, div_d;
  logic [POS_W-1:0]        pos_q, pos_d;
  logic                    bclk_q, bclk_d;
  logic                    ws_q, ws_d;
  logic [SAMPLE_WIDTH-1:0] shift_q, shift_d;
  logic                    underrun_q, underrun_d;
  logic                    busy_q, busy_d;

  // Holding registers, index 0 = left, 1 = right.
  logic [SAMPLE_WIDTH-1:0] hold_q [2];
  logic [SAMPLE_WIDTH-1:0] hold_d [2];
  logic [1:0]              full_q, full_d;

  // Combinational helpers.
  logic                    xfer;
  logic [1:0]              latch_req;
  logic [POS_W-1:0]        pos_next;

  // The ready flag looks only at the addressed channel so a full left word
  // never blocks a right-channel write and vice versa.
  assign sample_ready = ~full_q[channel_id];
  assign xfer         = sample_valid & sample_ready;

  // Next-state logic: bit-clock divider, bit position, slot latching and
  // holding-register bookkeeping.
  always_comb begin
    state_d    = state_q;
    div_d      = div_q;
    pos_d      = pos_q;
    bclk_d     = bclk_q;
    ws_d       = ws_q;
    shift_d    = shift_q;
    busy_d     = busy_q;
    underrun_d = 1'b0;
    full_d     = full_q;
    hold_d[0]  = hold_q[0];
    hold_d[1]  = hold_q[1];
    latch_req  = 2'b00;
    // Frame length need not be a power of two, so wrap explicitly.
    pos_next   = (pos_q == POS_LAST) ? '0 : pos_q + POS_W'(1);

    case (state_q)
      ST_IDLE: begin
        div_d   = '0;
        pos_d   = '0;
        bclk_d  = 1'b0;
        ws_d    = 1'b0;
        shift_d = '0;
        busy_d  = 1'b0;
        if (tx_en) begin
          // Frame starts immediately at pos 0 with the left word loaded.
          state_d      = ST_TX;
          busy_d       = 1'b1;
          latch_req[0] = 1'b1;
        end
      end

      ST_TX: begin
        if (div_q == DIV_LAST) begin
          div_d  = '0;
          bclk_d = ~bclk_q;
          // bclk high -> low: everything visible on the serial side moves here,
          // so sd and ws are stable around the following rising edge.
          if (bclk_q) begin
            pos_d   = pos_next;
            shift_d = {shift_q[SAMPLE_WIDTH-2:0], 1'b0};
            // ws leads the data by one bit: high from pos W-1 up to 2W-2.
            ws_d    = (pos_next >= POS_WS_RISE) && (pos_next != POS_LAST);
            if (pos_q == POS_LAST) begin
              if (!tx_en) begin
                // Stop only on a frame boundary; serial lines park low.
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                bclk_d  = 1'b0;
                ws_d    = 1'b0;
                shift_d = '0;
              end else begin
                latch_req[0] = 1'b1;
              end
            end else if (pos_next == POS_HALF) begin
              latch_req[1] = 1'b1;
            end
          end
        end else begin
          div_d = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Slot latch uses the flag as it stood before this cycle's write, so a
    // word arriving in the latch cycle waits for the next frame.
    for (int i = 0; i < 2; i++) begin
      if (latch_req[i]) begin
        if (full_q[i]) begin
          shift_d   = hold_q[i];
          full_d[i] = 1'b0;
        end else begin
          shift_d    = '0;
          underrun_d = 1'b1;
        end
      end
    end

    // A write can only happen into an empty register, so it never collides
    // with a latch clearing the same flag.
    if (xfer) begin
      hold_d[channel_id] = sample_in;
      full_d[channel_id] = 1'b1;
    end
  end

  // State register with asynchronous reset; reset discards any held words.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      state_q    <= ST_IDLE;
      div_q      <= '0;
      pos_q      <= '0;
      bclk_q     <= 1'b0;
      ws_q       <= 1'b0;
      shift_q    <= '0;
      underrun_q <= 1'b0;
      busy_q     <= 1'b0;
      full_q     <= 2'b00;
      hold_q[0]  <= '0;
      hold_q[1]  <= '0;
    end else begin
      state_q    <= state_d;
      div_q      <= div_d;
      pos_q      <= pos_d;
      bclk_q     <= bclk_d;
      ws_q       <= ws_d;
      shift_q    <= shift_d;
      underrun_q <= underrun_d;
      busy_q     <= busy_d;
      full_q     <= full_d;
      hold_q[0]  <= hold_d[0];
      hold_q[1]  <= hold_d[1];
    end
  end

  assign i2s_bclk = bclk_q;
  assign i2s_ws   = ws_q;
  assign i2s_sd   = shift_q[SAMPLE_WIDTH-1];
  assign underrun = underrun_q;
  assign busy     = busy_q;

endmodule
